// File: rtl/mul_pkg.sv
// Shared types and constants for the mul_top result-side collector.
// Status bit positions follow the {NV,DZ,OF,UF,NX} flag vector produced by mul_top.
package mul_pkg;

    localparam int unsigned STATUS_W = 5;

    localparam int unsigned ST_NV = 4;
    localparam int unsigned ST_DZ = 3;
    localparam int unsigned ST_OF = 2;
    localparam int unsigned ST_UF = 1;
    localparam int unsigned ST_NX = 0;

    localparam int unsigned MUL_EXPO_W = 8;
    localparam int unsigned MUL_MANT_W = 23;
    localparam int unsigned MUL_W      = 1 + MUL_EXPO_W + MUL_MANT_W;

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RDN = 2'd2,
        RND_RUP = 2'd3
    } rnd_e;

    typedef struct packed {
        logic [MUL_W-1:0]    res;
        logic [STATUS_W-1:0] status;
    } mul_rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// Generic first-word-fall-through synchronous FIFO; head is visible on rdata while non-empty.
// Pointers wrap at DEPTH-1 so DEPTH does not have to be a power of two.
module rsp_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mul_rsp_collector.sv
// Request/response wrapper around a fixed-latency mul_top: registers operands, tracks
// each accepted request through the pipeline, and buffers results in order under credit.
module mul_rsp_collector
    import mul_pkg::*;
#(
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned LAT    = 3,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned W     = 1 + EXPO_W + MANT_W,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [W-1:0]        req_a,
    input  logic [W-1:0]        req_b,
    input  logic [1:0]          req_rnd,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    output logic [1:0]          mul_rnd,
    input  logic [W-1:0]        mul_res,
    input  logic [STATUS_W-1:0] mul_status,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_res,
    output logic [STATUS_W-1:0] rsp_status,
    output logic [OCC_W-1:0]    occ
);

    typedef struct packed {
        logic [W-1:0]        res;
        logic [STATUS_W-1:0] status;
    } rsp_t;

    logic       accept;
    logic       pop;
    logic       push;
    logic       fifo_full;
    logic       fifo_empty;
    logic [LAT:0] trk;
    rsp_t       push_data;
    rsp_t       head;

    // Credit covers in-flight plus buffered entries, so a push always finds a free slot.
    assign req_ready = (occ < OCC_W'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = trk[LAT];

    assign push_data.res    = mul_res;
    assign push_data.status = mul_status;
    assign rsp_res          = head.res;
    assign rsp_status       = head.status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_rnd <= '0;
        end else if (accept) begin
            mul_a   <= req_a;
            mul_b   <= req_b;
            mul_rnd <= req_rnd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk <= '0;
        end else begin
            trk <= {trk[LAT-1:0], accept};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    rsp_fifo #(
        .WIDTH($bits(rsp_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop)
    ) else $error("mul_rsp_collector: result pushed into full buffer");

endmodule

// File: tb/tb_mul_rsp_collector.sv
// Self-checking bench for mul_rsp_collector with a behavioural fixed-latency mul_top stand-in.
// A negedge monitor keeps an in-order scoreboard and a reference outstanding count.
module tb_mul_rsp_collector;
    import mul_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_rnd;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [1:0]  mul_rnd;
    logic [31:0] mul_res;
    logic [4:0]  mul_status;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic [4:0]  rsp_status;
    logic [2:0]  occ;

    int tests = 0;
    int fails = 0;
    int occ_m = 0;
    int occ_max = 0;
    int rsp_cnt = 0;
    bit mon_en = 0;
    mul_rsp_t sbq[$];

    mul_rsp_collector #(
        .EXPO_W(8),
        .MANT_W(23),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rnd    (req_rnd),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_rnd    (mul_rnd),
        .mul_res    (mul_res),
        .mul_status (mul_status),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_status (rsp_status),
        .occ        (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for mul_top: known FP cases from the plan, a fixed scramble otherwise.
    function automatic mul_rsp_t mul_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] rnd);
        mul_rsp_t r;
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) begin
            r.res = 32'h4000_0000; r.status = 5'd0;
        end else if (a == 32'h7F80_0000 && b == 32'h0000_0000) begin
            r.res = 32'h7FC0_0000; r.status = 5'(1 << ST_NV);
        end else if (a == 32'h7F7F_FFFF && b == 32'h4000_0000) begin
            r.res = 32'h7F80_0000; r.status = 5'((1 << ST_OF) | (1 << ST_NX));
        end else begin
            r.res    = a ^ {b[15:0], b[31:16]} ^ {30'd0, rnd};
            r.status = a[4:0] ^ b[9:5] ^ {3'd0, rnd};
        end
        return r;
    endfunction

    mul_rsp_t pipe [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= mul_model(mul_a, mul_b, mul_rnd);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_res    = pipe[LAT-1].res;
    assign mul_status = pipe[LAT-1].status;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic acc;
        logic pp;
        mul_rsp_t e;
        if (mon_en && rst_n) begin
            acc = req_valid && req_ready;
            pp  = rsp_valid && rsp_ready;
            check("mon_occ", 64'(occ), 64'(occ_m));
            check("mon_req_ready", 64'(req_ready), 64'(occ_m < DEPTH));
            if (int'(occ) > occ_max) occ_max = int'(occ);
            if (pp) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_pop: response %0h with no outstanding request", rsp_res);
                end else begin
                    e = sbq.pop_front();
                    check("sb_res", 64'(rsp_res), 64'(e.res));
                    check("sb_status", 64'(rsp_status), 64'(e.status));
                    rsp_cnt++;
                end
            end
            if (acc) sbq.push_back(mul_model(req_a, req_b, req_rnd));
            occ_m = occ_m + int'(acc) - int'(pp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i);
        req_a   = 32'h1234_5678 + 32'(i) * 32'h0F0F_1111;
        req_b   = 32'h3F00_0001 + 32'(i) * 32'h0011_2233;
        req_rnd = 2'(i);
    endtask

    function automatic mul_rsp_t gen_exp(input int i);
        return mul_model(32'h1234_5678 + 32'(i) * 32'h0F0F_1111,
                         32'h3F00_0001 + 32'(i) * 32'h0011_2233, 2'(i));
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rnd;
        logic [31:0] res;
        logic [4:0]  st;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int n;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_a = v.a; req_b = v.b; req_rnd = v.rnd;
        check("vec_req_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("vec_mul_a", 64'(mul_a), 64'(v.a));
        check("vec_mul_b", 64'(mul_b), 64'(v.b));
        check("vec_mul_rnd", 64'(mul_rnd), 64'(v.rnd));
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 20);
        check("vec_latency", 64'(n), 64'(LAT + 1));
        check("vec_res", 64'(rsp_res), 64'(v.res));
        check("vec_status", 64'(rsp_status), 64'(v.st));
        tick();
        check("vec_occ_after_pop", 64'(occ), 64'd0);
        check("vec_valid_after_pop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        mul_rsp_t m;
        mul_rsp_t held;
        int n;
        int sent;
        int base;

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_rnd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_occ", 64'(occ), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        check("rst_mul_rnd", 64'(mul_rnd), 64'd0);
        check("rst_rsp_res", 64'(rsp_res), 64'd0);
        check("rst_rsp_status", 64'(rsp_status), 64'd0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, RND_RNE, 32'h4000_0000, 5'd0};
        vecs[1] = '{32'h7F80_0000, 32'h0000_0000, RND_RNE, 32'h7FC0_0000, 5'd16};
        vecs[2] = '{32'h7F7F_FFFF, 32'h4000_0000, RND_RNE, 32'h7F80_0000, 5'd5};
        m = mul_model(32'hDEAD_BEEF, 32'h0BAD_F00D, RND_RUP);
        vecs[3] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, RND_RUP, m.res, m.status};
        m = mul_model(32'h8000_0001, 32'hFFFF_FFFF, RND_RTZ);
        vecs[4] = '{32'h8000_0001, 32'hFFFF_FFFF, RND_RTZ, m.res, m.status};
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Backpressure: five back-to-back offers with the consumer stalled.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i);
            tick();
        end
        set_req(4);
        check("bp_req_ready", 64'(req_ready), 64'd0);
        check("bp_occ", 64'(occ), 64'd4);
        repeat (LAT + 3) tick();
        check("bp_valid", 64'(rsp_valid), 64'd1);
        check("bp_head", 64'(rsp_res), 64'(gen_exp(0).res));
        held.res = rsp_res;
        held.status = rsp_status;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_res", 64'(rsp_res), 64'(held.res));
            check("bp_hold_status", 64'(rsp_status), 64'(held.status));
            check("bp_still_full", 64'(req_ready), 64'd0);
        end

        // Release exactly one slot; the pending fifth request takes it.
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rel_occ", 64'(occ), 64'd3);
        check("rel_req_ready", 64'(req_ready), 64'd1);
        check("rel_head", 64'(rsp_res), 64'(gen_exp(1).res));
        tick();
        req_valid = 1'b0;
        check("rel_occ_refill", 64'(occ), 64'd4);
        check("rel_req_ready_full", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            n = 0;
            while (!rsp_valid && n < 20) begin
                tick();
                n++;
            end
            check("rel_drain_res", 64'(rsp_res), 64'(gen_exp(j).res));
            check("rel_drain_status", 64'(rsp_status), 64'(gen_exp(j).status));
            tick();
        end
        check("rel_drained_occ", 64'(occ), 64'd0);

        // Streaming: always offering, always consuming.
        occ_max = 0;
        base = rsp_cnt;
        sent = 0;
        n = 0;
        req_valid = 1'b1;
        set_req(10);
        while (sent < 20 && n < 200) begin
            logic acc_now;
            acc_now = req_ready;
            tick();
            n++;
            if (acc_now) begin
                sent++;
                set_req(10 + sent);
            end
        end
        req_valid = 1'b0;
        check("stream_sent", 64'(sent), 64'd20);
        n = 0;
        while (rsp_cnt < base + 20 && n < 100) begin
            tick();
            n++;
        end
        check("stream_received", 64'(rsp_cnt - base), 64'd20);
        check("stream_occ_bound", 64'(occ_max <= LAT + 1), 64'd1);
        check("stream_occ_reached", 64'(occ_max), 64'(DEPTH));
        check("stream_occ_end", 64'(occ), 64'd0);

        // Reset with two requests in flight.
        req_valid = 1'b1;
        set_req(30);
        tick();
        set_req(31);
        tick();
        req_valid = 1'b0;
        tick();
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_occ", 64'(occ), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_mul_a", 64'(mul_a), 64'd0);
        check("mid_rst_rsp_res", 64'(rsp_res), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        occ_m = 0;
        mon_en = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            check("post_rst_no_valid", 64'(rsp_valid), 64'd0);
            tick();
        end
        run_vec(vecs[2]);

        mon_en = 1'b0;
        check("final_sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
